// File: rtl/sort_engine_if.sv
// Memory-style bus: address, write data, write enable and combinational read data.
// The sort engine is master on the memory side and slave on the debug-unit side.
interface sort_engine_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/sort_engine.sv
// In-place bubble sorter over an external single-port memory (async read, sync write).
// Runtime direction, early exit on a swap-free pass, saturating busy-cycle counter.
// While idle the debug-unit port passes straight through to the memory.
// Optional feature macro: SORT_SIGNED_EN -- when defined, elements compare as
// two's-complement signed values; otherwise they compare unsigned.
module sort_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int N      = 256,
    parameter int CYC_W  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    input  logic             descend,
    output logic             busy,
    output logic             done,
    output logic [CYC_W-1:0] cycles,
    sort_engine_if.master    mem,
    sort_engine_if.slave     dbg
);

    if (N < 2 || N > (1 << ADDR_W)) begin : g_bad_n
        $error("sort_engine: N must satisfy 2 <= N <= 2**ADDR_W");
    end

    // j and limit need one extra bit so that limit can hold N == 2**ADDR_W
    localparam logic [ADDR_W:0]  ONE_J   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]  TWO_J   = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0]  N_J     = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0]  ZERO_J  = (ADDR_W+1)'(0);
    localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_A     = 3'd1,
        S_RD_B     = 3'd2,
        S_WR_A     = 3'd3,
        S_WR_B     = 3'd4,
        S_PASS_END = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t            state_r;
    logic              dir_r;
    logic [ADDR_W:0]   j_r;
    logic [ADDR_W:0]   limit_r;
    logic              swapped_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic              busy_r;
    logic              done_r;
    logic [CYC_W-1:0]  cycles_r;

    logic [ADDR_W:0]   j_p1_s;
    logic              pass_last_s;
    logic              swap_s;
    logic [ADDR_W-1:0] fsm_addr_s;
    logic [DATA_W-1:0] fsm_wdata_s;
    logic              fsm_we_s;

    // True when the pair (a, b) is out of order for the requested direction;
    // equal elements never swap, which keeps the sort stable.
    function automatic logic needs_swap(input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b,
                                        input logic              dir);
`ifdef SORT_SIGNED_EN
        return dir ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
`else
        return dir ? (a < b) : (a > b);
`endif
    endfunction

    assign j_p1_s      = j_r + ONE_J;
    assign pass_last_s = ((j_r + TWO_J) == limit_r);
    assign swap_s      = needs_swap(a_r, mem.rdata, dir_r);

    // Sort sequencer: reads a pair, swaps it if out of order, walks the pass, shrinks the limit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= S_IDLE;
            dir_r     <= 1'b0;
            j_r       <= ZERO_J;
            limit_r   <= ZERO_J;
            swapped_r <= 1'b0;
            a_r       <= {DATA_W{1'b0}};
            b_r       <= {DATA_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cycles_r  <= {CYC_W{1'b0}};
        end else begin
            if (busy_r && (cycles_r != CYC_MAX)) begin
                cycles_r <= cycles_r + CYC_ONE;
            end
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (run) begin
                        dir_r     <= descend;
                        j_r       <= ZERO_J;
                        limit_r   <= N_J;
                        swapped_r <= 1'b0;
                        cycles_r  <= {CYC_W{1'b0}};
                        done_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= S_RD_A;
                    end
                end
                S_RD_A: begin
                    a_r     <= mem.rdata;
                    state_r <= S_RD_B;
                end
                S_RD_B: begin
                    b_r <= mem.rdata;
                    if (swap_s) begin
                        swapped_r <= 1'b1;
                        state_r   <= S_WR_A;
                    end else if (pass_last_s) begin
                        state_r <= S_PASS_END;
                    end else begin
                        j_r     <= j_p1_s;
                        state_r <= S_RD_A;
                    end
                end
                S_WR_A: begin
                    state_r <= S_WR_B;
                end
                S_WR_B: begin
                    if (pass_last_s) begin
                        state_r <= S_PASS_END;
                    end else begin
                        j_r     <= j_p1_s;
                        state_r <= S_RD_A;
                    end
                end
                S_PASS_END: begin
                    if (!swapped_r || (limit_r == TWO_J)) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        limit_r   <= limit_r - ONE_J;
                        j_r       <= ZERO_J;
                        swapped_r <= 1'b0;
                        state_r   <= S_RD_A;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Memory access the sequencer wants in its current state
    always_comb begin
        fsm_addr_s  = j_r[ADDR_W-1:0];
        fsm_wdata_s = {DATA_W{1'b0}};
        fsm_we_s    = 1'b0;
        case (state_r)
            S_RD_B: begin
                fsm_addr_s = j_p1_s[ADDR_W-1:0];
            end
            S_WR_A: begin
                fsm_wdata_s = b_r;
                fsm_we_s    = 1'b1;
            end
            S_WR_B: begin
                fsm_addr_s  = j_p1_s[ADDR_W-1:0];
                fsm_wdata_s = a_r;
                fsm_we_s    = 1'b1;
            end
            default: begin
                fsm_addr_s = j_r[ADDR_W-1:0];
            end
        endcase
    end

    // Memory port owner: the sequencer while busy (debug writes dropped), else the debug unit
    always_comb begin
        if (busy_r) begin
            mem.addr  = fsm_addr_s;
            mem.wdata = fsm_wdata_s;
            mem.we    = fsm_we_s;
        end else begin
            mem.addr  = dbg.addr;
            mem.wdata = dbg.wdata;
            mem.we    = dbg.we;
        end
    end

    assign dbg.rdata = mem.rdata;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cycles    = cycles_r;

endmodule

// File: tb/tb_sort_engine.sv
// Directed bench for sort_engine with a result scoreboard.
// Three instances: A (N=16), B (N=4), C (N=4, 4-bit saturating cycle counter).
// Memories are loaded and read back through each instance's debug port.
module tb_sort_engine;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  run_v   = 3'b000;
    logic [2:0]  d_we    = 3'b000;
    logic        descend = 1'b0;
    logic [3:0]  d_addr  = 4'd0;
    logic [31:0] d_wdata = 32'd0;

    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [15:0] cyc_a, cyc_b;
    logic [3:0]  cyc_c;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [63:0] cyc_q[$];

    sort_engine_if #(.ADDR_W(4), .DATA_W(32)) mem_a ();
    sort_engine_if #(.ADDR_W(4), .DATA_W(32)) dbg_a ();
    sort_engine_if #(.ADDR_W(2), .DATA_W(32)) mem_b ();
    sort_engine_if #(.ADDR_W(2), .DATA_W(32)) dbg_b ();
    sort_engine_if #(.ADDR_W(2), .DATA_W(32)) mem_c ();
    sort_engine_if #(.ADDR_W(2), .DATA_W(32)) dbg_c ();

    logic [31:0] ram_a [16];
    logic [31:0] ram_b [4];
    logic [31:0] ram_c [4];

    assign dbg_a.addr = d_addr;       assign dbg_a.wdata = d_wdata; assign dbg_a.we = d_we[0];
    assign dbg_b.addr = d_addr[1:0];  assign dbg_b.wdata = d_wdata; assign dbg_b.we = d_we[1];
    assign dbg_c.addr = d_addr[1:0];  assign dbg_c.wdata = d_wdata; assign dbg_c.we = d_we[2];

    assign mem_a.rdata = ram_a[mem_a.addr];
    assign mem_b.rdata = ram_b[mem_b.addr];
    assign mem_c.rdata = ram_c[mem_c.addr];

    always @(posedge clk) if (mem_a.we) ram_a[mem_a.addr] <= mem_a.wdata;
    always @(posedge clk) if (mem_b.we) ram_b[mem_b.addr] <= mem_b.wdata;
    always @(posedge clk) if (mem_c.we) ram_c[mem_c.addr] <= mem_c.wdata;

    sort_engine #(.DATA_W(32), .ADDR_W(4), .N(16), .CYC_W(16)) u_a (
        .clk(clk), .rstn(rstn), .run(run_v[0]), .descend(descend),
        .busy(busy_a), .done(done_a), .cycles(cyc_a), .mem(mem_a), .dbg(dbg_a));
    sort_engine #(.DATA_W(32), .ADDR_W(2), .N(4), .CYC_W(16)) u_b (
        .clk(clk), .rstn(rstn), .run(run_v[1]), .descend(descend),
        .busy(busy_b), .done(done_b), .cycles(cyc_b), .mem(mem_b), .dbg(dbg_b));
    sort_engine #(.DATA_W(32), .ADDR_W(2), .N(4), .CYC_W(4)) u_c (
        .clk(clk), .rstn(rstn), .run(run_v[2]), .descend(descend),
        .busy(busy_c), .done(done_c), .cycles(cyc_c), .mem(mem_c), .dbg(dbg_c));

    function automatic logic done_of(input int sel);
        case (sel)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic [63:0] cyc_of(input int sel);
        case (sel)
            0: return 64'(cyc_a);
            1: return 64'(cyc_b);
            default: return 64'(cyc_c);
        endcase
    endfunction

    function automatic logic [31:0] rd_of(input int sel);
        case (sel)
            0: return dbg_a.rdata;
            1: return dbg_b.rdata;
            default: return dbg_c.rdata;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dbg_write(input int sel, input int idx, input logic [31:0] val);
        d_addr      = 4'(idx);
        d_wdata     = val;
        d_we[sel]   = 1'b1;
        @(posedge clk); #1;
        d_we        = 3'b000;
    endtask

    task automatic load4(input int sel, input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] v3);
        dbg_write(sel, 0, v0);
        dbg_write(sel, 1, v1);
        dbg_write(sel, 2, v2);
        dbg_write(sel, 3, v3);
    endtask

    task automatic expect4(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [31:0] v3, input logic [63:0] cyc);
        exp_q.push_back(v0); exp_q.push_back(v1); exp_q.push_back(v2); exp_q.push_back(v3);
        cyc_q.push_back(cyc);
    endtask

    task automatic pulse_run(input int sel);
        run_v[sel] = 1'b1;
        @(posedge clk); #1;
        run_v = 3'b000;
    endtask

    task automatic wait_done(input int sel, input string tag);
        for (int k = 0; k < 2000; k++) begin
            if (done_of(sel)) break;
            @(posedge clk); #1;
        end
        chk({tag, "_done"}, 64'(done_of(sel)), 64'd1);
        chk({tag, "_busy"}, 64'(busy_of(sel)), 64'd0);
    endtask

    task automatic check_results(input int sel, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            d_addr = 4'(i);
            #1;
            chk($sformatf("%s_mem%0d", tag, i), 64'(rd_of(sel)), 64'(exp_q.pop_front()));
        end
        chk({tag, "_cycles"}, cyc_of(sel), cyc_q.pop_front());
        @(posedge clk); #1;
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_busy_a", 64'(busy_a), 64'd0);
        chk("rst_done_a", 64'(done_a), 64'd0);
        chk("rst_cyc_a",  64'(cyc_a),  64'd0);
        chk("rst_busy_b", 64'(busy_b), 64'd0);
        chk("rst_done_c", 64'(done_c), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // 1: already-sorted 16 elements, one swap-free pass
        for (int i = 0; i < 16; i++) begin
            dbg_write(0, i, 32'(i));
            exp_q.push_back(32'(i));
        end
        cyc_q.push_back(64'd31);
        descend = 1'b0;
        pulse_run(0);
        wait_done(0, "t1");
        check_results(0, 16, "t1");

        // 2: reversed 4 elements, ascending
        load4(1, 32'd4, 32'd3, 32'd2, 32'd1);
        expect4(32'd1, 32'd2, 32'd3, 32'd4, 64'd27);
        descend = 1'b0;
        pulse_run(1);
        wait_done(1, "t2");
        check_results(1, 4, "t2");

        // 3: descending; direction input flips mid-sort and must be ignored
        load4(1, 32'd1, 32'd2, 32'd3, 32'd4);
        expect4(32'd4, 32'd3, 32'd2, 32'd1, 64'd27);
        descend = 1'b1;
        pulse_run(1);
        repeat (3) begin @(posedge clk); #1; end
        descend = 1'b0;
        wait_done(1, "t3");
        check_results(1, 4, "t3");

        // 4: top-bit-set element, ordering depends on signedness
        load4(1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd5);
`ifdef SORT_SIGNED_EN
        expect4(32'hFFFF_FFFF, 32'd0, 32'd1, 32'd5, 64'd14);
`else
        expect4(32'd0, 32'd1, 32'd5, 32'hFFFF_FFFF, 64'd23);
`endif
        descend = 1'b0;
        pulse_run(1);
        wait_done(1, "t4");
        check_results(1, 4, "t4");

        // 5a: run pulse and debug write while busy are both ignored
        load4(1, 32'd4, 32'd3, 32'd2, 32'd1);
        expect4(32'd1, 32'd2, 32'd3, 32'd4, 64'd27);
        pulse_run(1);
        repeat (4) begin @(posedge clk); #1; end
        chk("t5_busy_mid", 64'(busy_b), 64'd1);
        run_v[1] = 1'b1;
        d_addr   = 4'd0;
        d_wdata  = 32'hDEAD_BEEF;
        d_we[1]  = 1'b1;
        @(posedge clk); #1;
        run_v = 3'b000;
        d_we  = 3'b000;
        wait_done(1, "t5");
        check_results(1, 4, "t5");

        // 5b: 4-bit cycle counter saturates
        load4(2, 32'd4, 32'd3, 32'd2, 32'd1);
        expect4(32'd1, 32'd2, 32'd3, 32'd4, 64'd15);
        pulse_run(2);
        wait_done(2, "t5c");
        check_results(2, 4, "t5c");

        // 6: reset mid-sort aborts at once, then a fresh sort completes
        load4(1, 32'd4, 32'd3, 32'd2, 32'd1);
        pulse_run(1);
        repeat (6) begin @(posedge clk); #1; end
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(busy_b), 64'd0);
        chk("t6_rst_done", 64'(done_b), 64'd0);
        chk("t6_rst_cyc",  64'(cyc_b),  64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        load4(1, 32'd2, 32'd4, 32'd1, 32'd3);
        expect4(32'd1, 32'd2, 32'd3, 32'd4, 64'd21);
        descend = 1'b0;
        pulse_run(1);
        wait_done(1, "t6");
        check_results(1, 4, "t6");

        chk("sb_empty", 64'(exp_q.size() + cyc_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
